smss_sbox_layer_seq: RTL and testbench

Sequential S-box layer driver for the 6-bit SMSS S-box family. It accepts an N_SBOX×6-bit state word over a valid/ready handshake and feeds the 6-bit words one per cycle into an external combinational S-box core. It collects the core's outputs and presents the substituted state over a second valid/ready handshake. It sits directly around the S-box core, upstream and downstream of it, so that a single core instance serves a whole cipher state.

---
 rtl/smss_pkg.sv | 22 ++
 rtl/smss_sbox_layer_seq_if.sv | 23 ++
 rtl/smss_word_sel.sv | 33 +++
 rtl/smss_sbox_layer_seq.sv | 129 ++++++++++++
 tb/tb_smss_sbox_layer_seq.sv | 298 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/smss_pkg.sv
// Shared definitions for the SMSS S-box layer: word width, FSM encoding and
// the helper that locates a 6-bit word inside a packed state vector.
package smss_pkg;

  localparam int SMSS_W = 6;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = IDLE,
    ST_RUN  = RUN,
    ST_DONE = DONE
  } smss_state_e;

  // Bit offset of word k; word k occupies [lsb+5:lsb].
  function automatic int unsigned smss_word_lsb(input int unsigned k);
    return k * SMSS_W;
  endfunction

endpackage

// File: rtl/smss_sbox_layer_seq_if.sv
// Input and output valid/ready handshakes of the sequential S-box layer.
interface smss_sbox_layer_seq_if #(
  parameter int N_SBOX = 8
);

  logic                                  in_valid;
  logic                                  in_ready;
  logic [smss_pkg::SMSS_W*N_SBOX-1:0]    in_data;
  logic                                  out_valid;
  logic                                  out_ready;
  logic [smss_pkg::SMSS_W*N_SBOX-1:0]    out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );

endinterface

// File: rtl/smss_word_sel.sv
// N_SBOX:1 word read mux over the work register plus a one-hot write-enable
// decode addressing the result register.
module smss_word_sel
  import smss_pkg::*;
#(
  parameter int N_SBOX = 8,
  parameter int IW     = $clog2(N_SBOX) + 1
) (
  input  logic [SMSS_W*N_SBOX-1:0] work_data,
  input  logic [IW-1:0]            rd_idx,
  input  logic                     wr_en,
  input  logic [IW-1:0]            wr_idx,
  output logic [SMSS_W-1:0]        rd_word,
  output logic [N_SBOX-1:0]        wr_mask
);

  logic [SMSS_W-1:0] words [N_SBOX];

  generate
    for (genvar gi = 0; gi < N_SBOX; gi++) begin : g_word
      assign words[gi]   = work_data[smss_word_lsb(gi) +: SMSS_W];
      assign wr_mask[gi] = wr_en && (wr_idx == IW'(gi));
    end
  endgenerate

  always_comb begin
    rd_word = '0;
    for (int k = 0; k < N_SBOX; k++) begin
      if (rd_idx == IW'(k)) rd_word = words[k];
    end
  end

endmodule

// File: rtl/smss_sbox_layer_seq.sv
// Time-multiplexes one external 6-bit S-box core over an N_SBOX-word state:
// words go out on sbox_x one per cycle and come back on sbox_y.
module smss_sbox_layer_seq
  import smss_pkg::*;
#(
  parameter int N_SBOX = 8,
  parameter int PIPE   = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  smss_sbox_layer_seq_if.slave  io,
  output logic [SMSS_W-1:0]     sbox_x,
  input  logic [SMSS_W-1:0]     sbox_y,
  output logic                  busy
);

  localparam int IW = $clog2(N_SBOX) + 1;
  localparam int DW = SMSS_W * N_SBOX;
  // With a registered core, RUN has one extra cycle to collect the last word.
  localparam logic [IW-1:0] LAST_IDX = (PIPE != 0) ? IW'(N_SBOX) : IW'(N_SBOX - 1);
  localparam logic [IW-1:0] MAX_RD   = IW'(N_SBOX - 1);

  smss_state_e       state_reg, state_next;
  logic [IW-1:0]     idx_reg, idx_next;
  logic [DW-1:0]     work_reg, work_next;
  logic [DW-1:0]     result_reg, result_next;
  logic [DW-1:0]     out_data_reg;
  logic              out_valid_reg;
  logic              busy_reg;
  logic              in_ready_c;

  logic              in_run;
  logic              last_cycle;
  logic              cap_en;
  logic [IW-1:0]     rd_idx;
  logic [IW-1:0]     cap_idx;
  logic [SMSS_W-1:0] rd_word;
  logic [N_SBOX-1:0] wr_mask;

  assign in_run     = (state_reg == ST_RUN);
  assign last_cycle = in_run && (idx_reg == LAST_IDX);
  assign rd_idx     = (idx_reg > MAX_RD) ? MAX_RD : idx_reg;
  assign cap_idx    = (PIPE != 0) ? idx_reg - 1'b1 : idx_reg;
  assign cap_en     = in_run && ((PIPE == 0) || (idx_reg != '0));
  assign sbox_x     = in_run ? rd_word : '0;

  smss_word_sel #(
    .N_SBOX (N_SBOX),
    .IW     (IW)
  ) u_word_sel (
    .work_data (work_reg),
    .rd_idx    (rd_idx),
    .wr_en     (cap_en),
    .wr_idx    (cap_idx),
    .rd_word   (rd_word),
    .wr_mask   (wr_mask)
  );

  generate
    for (genvar gi = 0; gi < N_SBOX; gi++) begin : g_result
      assign result_next[smss_word_lsb(gi) +: SMSS_W] =
        wr_mask[gi] ? sbox_y : result_reg[smss_word_lsb(gi) +: SMSS_W];
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    work_next  = work_reg;
    in_ready_c = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        in_ready_c = 1'b1;
        if (io.in_valid) begin
          work_next  = io.in_data;
          idx_next   = '0;
          state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        idx_next = idx_reg + 1'b1;
        if (last_cycle) begin
          idx_next   = '0;
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        // Accepting a new state while handing off the old one keeps the core busy.
        in_ready_c = io.out_ready;
        if (io.out_ready) begin
          if (io.in_valid) begin
            work_next  = io.in_data;
            idx_next   = '0;
            state_next = ST_RUN;
          end else begin
            state_next = ST_IDLE;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      idx_reg       <= '0;
      work_reg      <= '0;
      result_reg    <= '0;
      out_data_reg  <= '0;
      out_valid_reg <= 1'b0;
      busy_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      idx_reg       <= idx_next;
      work_reg      <= work_next;
      result_reg    <= result_next;
      out_valid_reg <= (state_next == ST_DONE);
      busy_reg      <= (state_next == ST_RUN);
      if (last_cycle) out_data_reg <= result_next;
    end
  end

  assign io.in_ready  = in_ready_c;
  assign io.out_valid = out_valid_reg;
  assign io.out_data  = out_data_reg;
  assign busy         = busy_reg;

endmodule

// File: tb/tb_smss_sbox_layer_seq.sv
// Randomised self-checking bench: one PIPE=0 instance with a selectable
// combinational core and one PIPE=1 instance with a registered core.
module tb_smss_sbox_layer_seq;
  import smss_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [5:0]  x_a, y_a, x_b, y_b;
  logic        busy_a, busy_b;
  int          core_mode;
  logic [5:0]  sbox_tab [64];
  logic [5:0]  trace_a [16];
  int          errors = 0;
  int          checks = 0;

  smss_sbox_layer_seq_if #(.N_SBOX(8)) if_a ();
  smss_sbox_layer_seq_if #(.N_SBOX(8)) if_b ();

  smss_sbox_layer_seq #(.N_SBOX(8), .PIPE(0)) dut_a (
    .clk (clk), .rst_n (rst_n), .io (if_a),
    .sbox_x (x_a), .sbox_y (y_a), .busy (busy_a)
  );

  smss_sbox_layer_seq #(.N_SBOX(8), .PIPE(1)) dut_b (
    .clk (clk), .rst_n (rst_n), .io (if_b),
    .sbox_x (x_b), .sbox_y (y_b), .busy (busy_b)
  );

  // GF(2^6) with x^6 = x + 1
  function automatic logic [5:0] gf_mul(input logic [5:0] a_in, input logic [5:0] b_in);
    logic [5:0] a, b, p;
    a = a_in; b = b_in; p = '0;
    for (int i = 0; i < 6; i++) begin
      if (b[0]) p = p ^ a;
      b = b >> 1;
      a = a[5] ? ({a[4:0], 1'b0} ^ 6'h03) : {a[4:0], 1'b0};
    end
    return p;
  endfunction

  function automatic logic [5:0] gf_pow52(input logic [5:0] x);
    logic [5:0] r;
    r = 6'h01;
    for (int i = 0; i < 52; i++) r = gf_mul(r, x);
    return r;
  endfunction

  always_comb begin
    case (core_mode)
      0:       y_a = x_a ^ 6'h3F;
      1:       y_a = x_a;
      2:       y_a = gf_pow52(x_a);
      default: y_a = sbox_tab[x_a];
    endcase
  end

  always @(posedge clk) y_b <= x_b ^ 6'h3F;

  // Reference: every word substituted independently through the chosen core.
  function automatic logic [47:0] model(input logic [47:0] d, input int mode);
    logic [47:0] r;
    logic [5:0]  w;
    r = '0;
    for (int k = 0; k < 8; k++) begin
      w = d[6*k +: 6];
      case (mode)
        0:       r[6*k +: 6] = w ^ 6'h3F;
        1:       r[6*k +: 6] = w;
        default: r[6*k +: 6] = sbox_tab[w];
      endcase
    end
    return r;
  endfunction

  task automatic run_a(input logic [47:0] d, output logic [47:0] res,
                       output int lat, output logic busy_first);
    if_a.in_data  = d;
    if_a.in_valid = 1'b1;
    @(posedge clk); #1;
    if_a.in_valid = 1'b0;
    busy_first = busy_a;
    lat = 0;
    while (!if_a.out_valid && lat < 40) begin
      if (lat < 16) trace_a[lat] = x_a;
      @(posedge clk); #1;
      lat++;
    end
    res = if_a.out_data;
    $display("txn a: in=%h out=%h latency=%0d", d, res, lat);
    @(posedge clk); #1;
  endtask

  task automatic run_b(input logic [47:0] d, output logic [47:0] res, output int lat);
    if_b.in_data  = d;
    if_b.in_valid = 1'b1;
    @(posedge clk); #1;
    if_b.in_valid = 1'b0;
    lat = 0;
    while (!if_b.out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    res = if_b.out_data;
    $display("txn b: in=%h out=%h latency=%0d", d, res, lat);
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    if_a.in_valid = 1'b0; if_a.in_data = '0; if_a.out_ready = 1'b1;
    if_b.in_valid = 1'b0; if_b.in_data = '0; if_b.out_ready = 1'b1;
    core_mode = 0;
    #12;
    checks++; if (if_a.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", if_a.out_valid); end
    checks++; if (if_a.out_data !== 48'h0) begin errors++; $display("FAIL reset_out_data: got %h expected 0", if_a.out_data); end
    checks++; if (x_a !== 6'h0) begin errors++; $display("FAIL reset_sbox_x: got %h expected 0", x_a); end
    checks++; if (if_a.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", if_a.in_ready); end
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy_a); end
    checks++; if (if_b.out_valid !== 1'b0 || if_b.in_ready !== 1'b1) begin errors++; $display("FAIL reset_b: got valid=%b ready=%b expected 0/1", if_b.out_valid, if_b.in_ready); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_xor_pipe0();
    logic [47:0] res, d;
    int lat;
    logic bf;
    core_mode = 0;
    d = 48'hFEDCBA987654;
    run_a(d, res, lat, bf);
    checks++; if (res !== 48'h0123456789AB) begin errors++; $display("FAIL xor_p0_data: got %h expected 0123456789ab", res); end
    checks++; if (lat != 8) begin errors++; $display("FAIL xor_p0_latency: got %0d expected 8", lat); end
    checks++; if (bf !== 1'b1) begin errors++; $display("FAIL xor_p0_busy: got %b expected 1", bf); end
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (trace_a[k] !== d[6*k +: 6]) begin
        errors++; $display("FAIL xor_p0_sbox_x[%0d]: got %h expected %h", k, trace_a[k], d[6*k +: 6]);
      end
    end
    checks++; if (x_a !== 6'h0) begin errors++; $display("FAIL idle_sbox_x: got %h expected 0", x_a); end
  endtask

  task automatic test_pipe1();
    logic [47:0] res, d;
    int lat;
    run_b(48'hFEDCBA987654, res, lat);
    checks++; if (res !== 48'h0123456789AB) begin errors++; $display("FAIL p1_data: got %h expected 0123456789ab", res); end
    checks++; if (lat != 9) begin errors++; $display("FAIL p1_latency: got %0d expected 9", lat); end
    for (int n = 0; n < 4; n++) begin
      d = 48'({$urandom(), $urandom()});
      run_b(d, res, lat);
      checks++; if (res !== model(d, 0)) begin errors++; $display("FAIL p1_rand_data: got %h expected %h", res, model(d, 0)); end
    end
  endtask

  task automatic test_power52_zero();
    logic [47:0] res;
    int lat;
    logic bf;
    core_mode = 2;
    run_a(48'h0, res, lat, bf);
    checks++; if (res !== 48'h0) begin errors++; $display("FAIL pow52_zero: got %h expected 0", res); end
  endtask

  task automatic test_random_table();
    logic [47:0] res, d;
    int lat;
    logic bf;
    for (int i = 0; i < 64; i++) sbox_tab[i] = 6'($urandom_range(63));
    core_mode = 3;
    for (int n = 0; n < 6; n++) begin
      d = 48'({$urandom(), $urandom()});
      run_a(d, res, lat, bf);
      checks++; if (res !== model(d, 3)) begin errors++; $display("FAIL rand_table: got %h expected %h", res, model(d, 3)); end
    end
  endtask

  task automatic test_identity_sweep();
    logic [47:0] res, d;
    int lat;
    logic bf;
    core_mode = 1;
    for (int v = 0; v < 8; v++) begin
      for (int k = 0; k < 8; k++) d[6*k +: 6] = 6'(v * 8 + k);
      run_a(d, res, lat, bf);
      checks++; if (res !== d) begin errors++; $display("FAIL identity_sweep: got %h expected %h", res, d); end
    end
  endtask

  task automatic test_backpressure();
    logic [47:0] da, db;
    int cnt;
    core_mode = 0;
    da = 48'({$urandom(), $urandom()});
    db = 48'({$urandom(), $urandom()});
    if_a.out_ready = 1'b0;
    if_a.in_data = da; if_a.in_valid = 1'b1;
    @(posedge clk); #1;
    if_a.in_data = db;
    checks++; if (if_a.in_ready !== 1'b0) begin errors++; $display("FAIL bp_run_in_ready: got %b expected 0", if_a.in_ready); end
    cnt = 0;
    while (!if_a.out_valid && cnt < 40) begin @(posedge clk); #1; cnt++; end
    checks++; if (cnt != 8) begin errors++; $display("FAIL bp_latency: got %0d expected 8", cnt); end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (if_a.in_ready !== 1'b0 || if_a.out_valid !== 1'b1 || if_a.out_data !== model(da, 0)) begin
        errors++; $display("FAIL bp_hold: got ready=%b valid=%b data=%h expected 0/1/%h",
                           if_a.in_ready, if_a.out_valid, if_a.out_data, model(da, 0));
      end
      @(posedge clk); #1;
    end
    if_a.out_ready = 1'b1;
    #1;
    checks++; if (if_a.in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready: got %b expected 1", if_a.in_ready); end
    @(posedge clk); #1;
    if_a.in_valid = 1'b0;
    checks++; if (busy_a !== 1'b1 || if_a.out_valid !== 1'b0) begin errors++; $display("FAIL bp_handoff: got busy=%b valid=%b expected 1/0", busy_a, if_a.out_valid); end
    cnt = 0;
    while (!if_a.out_valid && cnt < 40) begin @(posedge clk); #1; cnt++; end
    checks++; if (cnt != 8 || if_a.out_data !== model(db, 0)) begin errors++; $display("FAIL bp_second: got lat=%0d data=%h expected 8/%h", cnt, if_a.out_data, model(db, 0)); end
    $display("txn a: backpressure pair in=%h,%h out=%h", da, db, if_a.out_data);
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    logic [47:0] d [3];
    int cnt;
    core_mode = 0;
    for (int n = 0; n < 3; n++) d[n] = 48'({$urandom(), $urandom()});
    if_a.out_ready = 1'b1;
    if_a.in_data = d[0]; if_a.in_valid = 1'b1;
    @(posedge clk); #1;
    for (int n = 0; n < 3; n++) begin
      if (n < 2) if_a.in_data = d[n+1];
      else if_a.in_valid = 1'b0;
      cnt = 0;
      while (!if_a.out_valid && cnt < 30) begin @(posedge clk); #1; cnt++; end
      checks++;
      if (cnt != 8 || if_a.out_data !== model(d[n], 0)) begin
        errors++; $display("FAIL b2b[%0d]: got lat=%0d data=%h expected 8/%h", n, cnt, if_a.out_data, model(d[n], 0));
      end
      $display("txn a: b2b in=%h out=%h latency=%0d", d[n], if_a.out_data, cnt);
      @(posedge clk); #1;
    end
    checks++; if (busy_a !== 1'b0 || if_a.in_ready !== 1'b1) begin errors++; $display("FAIL b2b_idle: got busy=%b ready=%b expected 0/1", busy_a, if_a.in_ready); end
  endtask

  task automatic test_reset_mid_run();
    logic [47:0] res, d;
    int lat;
    logic bf;
    core_mode = 0;
    d = 48'({$urandom(), $urandom()});
    if_a.in_data = d; if_a.in_valid = 1'b1;
    @(posedge clk); #1;
    if_a.in_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    checks++; if (busy_a !== 1'b1) begin errors++; $display("FAIL mid_run_busy: got %b expected 1", busy_a); end
    rst_n = 1'b0;
    #1;
    checks++;
    if (if_a.out_valid !== 1'b0 || if_a.out_data !== 48'h0 || x_a !== 6'h0 ||
        if_a.in_ready !== 1'b1 || busy_a !== 1'b0) begin
      errors++; $display("FAIL mid_run_reset: got valid=%b data=%h x=%h ready=%b busy=%b expected 0/0/0/1/0",
                         if_a.out_valid, if_a.out_data, x_a, if_a.in_ready, busy_a);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    d = 48'({$urandom(), $urandom()});
    run_a(d, res, lat, bf);
    checks++; if (res !== model(d, 0) || lat != 8) begin errors++; $display("FAIL post_reset_txn: got %h lat=%0d expected %h lat=8", res, lat, model(d, 0)); end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_xor_pipe0();
    test_pipe1();
    test_power52_zero();
    test_random_table();
    test_identity_sweep();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
